// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring shift-subtract divider.
// Produces one quotient bit per clock; a divide by zero completes on the
// start edge with an error flag. start/busy/done handshake, outputs registered.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_rem;       // partial remainder; always < divisor, so WIDTH bits hold it
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;

  // The shifted partial remainder and trial difference are WIDTH+1 bits so
  // that bit WIDTH of the trial is the explicit borrow.
  logic [WIDTH:0]   w_shifted_rem;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_shift;

  // One restoring iteration: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    // NOTE: every signal gets a value on every pass; a missing assignment in
    // always_comb would infer a latch.
    w_shifted_rem = {r_rem, r_shift[WIDTH-1]};
    w_trial       = w_shifted_rem - {1'b0, r_divisor};
    w_qbit        = ~w_trial[WIDTH];
    w_next_rem    = w_qbit ? w_trial[WIDTH-1:0] : w_shifted_rem[WIDTH-1:0];
    w_next_shift  = {r_shift[WIDTH-2:0], w_qbit};
  end

  // Control FSM and datapath registers; the last iteration and completion share an edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= dividend;
            r_divisor <= divisor;
            r_rem     <= '0;
            r_count   <= CW'(WIDTH);
            if (divisor != '0) begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end else begin
              // Zero-latency error completion; state stays idle.
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_dbz     <= 1'b1;
              r_quot    <= '1;
              r_rem_out <= dividend;
            end
          end
        end
        S_CALC: begin
          r_rem   <= w_next_rem;
          r_shift <= w_next_shift;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_quot    <= w_next_shift;
            r_rem_out <= w_next_rem;
            r_done    <= 1'b1;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with hand-computed results plus a
// random sweep checked against integer division.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int t0      = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Present operands with start for one edge (E0); returns at the negedge after E0.
  task automatic issue(input int a, input int b);
    @(negedge clk);
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  // Wait (bounded) for done; latency is edges counted from E0.
  task automatic wait_done(output int lat);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    lat = cyc - t0;
  endtask

  task automatic run_check(input string tag, input int a, input int b);
    int lat;
    issue(a, b);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(WIDTH));
    check({tag, "_q"}, 32'(quotient), 32'(a / b));
    check({tag, "_r"}, 32'(remainder), 32'(a % b));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int a;
    int b;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 200 / 7 = 28 r 4, busy right after the start edge
    issue(200, 7);
    check("b1_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b1_lat", 32'(lat), 32'd8);
    check("b1_q", 32'(quotient), 32'd28);
    check("b1_r", 32'(remainder), 32'd4);
    check("b1_dbz", 32'(div_by_zero), 32'd0);
    check("b1_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("b1_pulse", 32'(done), 32'd0);
    check("b1_hold_q", 32'(quotient), 32'd28);
    check("b1_hold_r", 32'(remainder), 32'd4);

    // Corner values
    run_check("div1", 255, 1);
    run_check("small", 5, 9);
    run_check("zero", 0, 3);
    run_check("equal", 255, 255);

    // Divide by zero completes on the start edge
    issue(77, 0);
    check("dz_done", 32'(done), 32'd1);
    check("dz_flag", 32'(div_by_zero), 32'd1);
    check("dz_q", 32'(quotient), 32'hFF);
    check("dz_r", 32'(remainder), 32'd77);
    check("dz_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("dz_pulse", 32'(done), 32'd0);
    check("dz_busy2", 32'(busy), 32'd0);
    check("dz_hold", 32'(div_by_zero), 32'd1);

    // start while busy ignored; inputs changing mid-operation have no effect
    issue(100, 10);
    @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd55;
    divisor  = 8'd1;
    wait_done(lat);
    check("ign_lat", 32'(lat), 32'd8);
    check("ign_q", 32'(quotient), 32'd10);
    check("ign_r", 32'(remainder), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("ign_no_extra_done", 32'(seen), 32'd0);

    // Reset in the middle of CALC
    issue(150, 4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("mid_rst_idle", 32'(seen), 32'd0);
    run_check("after_rst", 150, 4);

    // Back-to-back: second start issued in the done cycle
    issue(13, 5);
    wait_done(lat);
    check("bb1_lat", 32'(lat), 32'd8);
    check("bb1_q", 32'(quotient), 32'd2);
    check("bb1_r", 32'(remainder), 32'd3);
    dividend = 8'd250;
    divisor  = 8'd16;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check("bb2_busy", 32'(busy), 32'd1);
    check("bb2_done_low", 32'(done), 32'd0);
    check("bb2_hold_q", 32'(quotient), 32'd2);
    wait_done(lat);
    check("bb2_lat", 32'(lat), 32'd8);
    check("bb2_q", 32'(quotient), 32'd15);
    check("bb2_r", 32'(remainder), 32'd10);

    // Random sweep against integer division
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 4 == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 255));
      run_check("rand", a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
